// File: rtl/whack_pkg.sv
// Shared types and widths for the whack-a-mole scheduler.
// Holds the FSM state enum, score/miss widths and default hole count.
package whack_pkg;

    localparam int SCORE_W     = 8;
    localparam int MISS_W      = 4;
    localparam int TMR_W       = 8;
    localparam int N_HOLES_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SHOW,
        ST_OVER
    } state_t;

endpackage

// File: rtl/tick_timer.sv
// Loadable 8-bit down-counter advanced by a tick strobe.
// Ports: clk, rst (async high), i_tick, i_load, i_load_val -> o_done.
// o_done is high on the tick that finishes the interval (count 1, or 0).
module tick_timer
    import whack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_done = i_tick && (r_count <= TMR_W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game scheduler: spawns moles, times them, scores hits/misses.
// Ports: clk, rst, tick, start, rand_in, whack -> shift_en, mole,
//        hit_pulse, miss_pulse, score, misses, game_over (all registered).
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int N_HOLES    = N_HOLES_DEF,
    parameter int GAP_BASE   = 4,
    parameter int UP_TICKS   = 100,
    parameter int MAX_MISSES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [9:0]         rand_in,
    input  logic [N_HOLES-1:0] whack,
    output logic               shift_en,
    output logic [N_HOLES-1:0] mole,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over
);

    localparam int HOLE_W = $clog2(N_HOLES);

    state_t               r_state;
    logic                 r_shift;
    logic [N_HOLES-1:0]   r_mole;
    logic                 r_hit;
    logic                 r_miss;
    logic [SCORE_W-1:0]   r_score;
    logic [MISS_W-1:0]    r_misses;
    logic                 r_go;
    logic [HOLE_W-1:0]    r_hole;
    logic                 r_prev_vld;

    state_t               w_state_nxt;
    logic                 w_shift_nxt;
    logic [N_HOLES-1:0]   w_mole_nxt;
    logic                 w_hit_nxt;
    logic                 w_miss_nxt;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [MISS_W-1:0]    w_misses_nxt;
    logic [HOLE_W-1:0]    w_hole_nxt;
    logic                 w_prev_vld_nxt;

    logic                 w_tmr_load;
    logic [TMR_W-1:0]     w_tmr_val;
    logic                 w_tmr_done;
    logic [TMR_W-1:0]     w_gap_ld;
    logic [HOLE_W-1:0]    w_raw;
    logic [HOLE_W-1:0]    w_pick;
    logic [N_HOLES-1:0]   w_pick_oh;
    logic                 w_hit_now;
    logic [MISS_W-1:0]    w_misses_inc;
    logic                 w_unused;

    tick_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (tick),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    assign w_gap_ld     = TMR_W'(GAP_BASE) + {4'd0, rand_in[9:6]};
    assign w_raw        = rand_in[HOLE_W-1:0];
    // Never show the same hole twice in a row; the first spawn of a game
    // has no predecessor.
    assign w_pick       = (r_prev_vld && (w_raw == r_hole)) ?
                          w_raw + HOLE_W'(1) : w_raw;
    assign w_pick_oh    = N_HOLES'(1) << w_pick;
    // r_mole is only non-zero in SHOW, so this also gates by state.
    assign w_hit_now    = |(whack & r_mole);
    assign w_misses_inc = r_misses + MISS_W'(1);
    assign w_unused     = ^rand_in[5:HOLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= 1'b0;
            r_mole     <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_score    <= '0;
            r_misses   <= '0;
            r_go       <= 1'b0;
            r_hole     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_mole     <= w_mole_nxt;
            r_hit      <= w_hit_nxt;
            r_miss     <= w_miss_nxt;
            r_score    <= w_score_nxt;
            r_misses   <= w_misses_nxt;
            r_go       <= (w_state_nxt == ST_OVER);
            r_hole     <= w_hole_nxt;
            r_prev_vld <= w_prev_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = 1'b0;
        w_mole_nxt     = r_mole;
        w_hit_nxt      = 1'b0;
        w_miss_nxt     = 1'b0;
        w_score_nxt    = r_score;
        w_misses_nxt   = r_misses;
        w_hole_nxt     = r_hole;
        w_prev_vld_nxt = r_prev_vld;
        w_tmr_load     = 1'b0;
        w_tmr_val      = w_gap_ld;
        unique case (r_state)
            ST_IDLE, ST_OVER: begin
                w_mole_nxt  = '0;
                w_shift_nxt = 1'b1;
                if (start) begin
                    w_state_nxt    = ST_GAP;
                    w_shift_nxt    = 1'b0;
                    w_score_nxt    = '0;
                    w_misses_nxt   = '0;
                    w_prev_vld_nxt = 1'b0;
                    w_tmr_load     = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_tmr_done) begin
                    w_state_nxt    = ST_SHOW;
                    w_shift_nxt    = 1'b1;
                    w_hole_nxt     = w_pick;
                    w_prev_vld_nxt = 1'b1;
                    w_mole_nxt     = w_pick_oh;
                    w_tmr_load     = 1'b1;
                    w_tmr_val      = TMR_W'(UP_TICKS);
                end
            end
            ST_SHOW: begin
                // A hit takes priority over a same-cycle expiry.
                if (w_hit_now) begin
                    w_state_nxt = ST_GAP;
                    w_hit_nxt   = 1'b1;
                    w_mole_nxt  = '0;
                    w_tmr_load  = 1'b1;
                    if (r_score != '1) begin
                        w_score_nxt = r_score + SCORE_W'(1);
                    end
                end else if (w_tmr_done) begin
                    w_miss_nxt   = 1'b1;
                    w_misses_nxt = w_misses_inc;
                    w_mole_nxt   = '0;
                    if (w_misses_inc == MISS_W'(MAX_MISSES)) begin
                        w_state_nxt = ST_OVER;
                        w_shift_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_tmr_load  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign shift_en   = r_shift;
    assign mole       = r_mole;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;
    assign score      = r_score;
    assign misses     = r_misses;
    assign game_over  = r_go;

endmodule
